bpred_btb: RTL

Parametrised branch predictor for the decode stage of the 16-bit pipelined core: a direct-mapped branch target buffer (BTB) with 2-bit saturating direction counters, a mispredict counter and a self-clearing initialisation sweep. Decode queries it combinationally with the fetch PC. Execute/writeback returns resolved outcomes through the update port. While it is busy, fetch must fall back to PC+1.

---
 rtl/bpred_pkg.sv | 21 ++
 rtl/bpred_btb_satcnt2.sv | 20 ++
 rtl/bpred_btb.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/bpred_pkg.sv
// Shared types and constants for the bpred_btb branch predictor:
// FSM state encoding, 2-bit counter constants and mispredict counter helpers.
package bpred_pkg;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    typedef logic [1:0] cnt_t;

    localparam cnt_t        CNT_MIN  = 2'b00;
    localparam cnt_t        CNT_INIT = 2'b10;
    localparam cnt_t        CNT_MAX  = 2'b11;
    localparam logic [15:0] MISS_MAX = 16'hFFFF;

    function automatic logic [15:0] miss_inc(input logic [15:0] v);
        return (v == MISS_MAX) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/bpred_btb_satcnt2.sv
// satcnt2: 2-bit saturating up/down counter used for the BTB direction
// prediction (increment on taken, decrement on not taken).
module satcnt2
    import bpred_pkg::*;
(
    input  cnt_t i_cnt,
    input  logic i_inc,
    output cnt_t o_cnt
);

    always_comb begin
        o_cnt = i_cnt;
        if (i_inc) begin
            if (i_cnt != CNT_MAX) o_cnt = i_cnt + 2'd1;
        end else begin
            if (i_cnt != CNT_MIN) o_cnt = i_cnt - 2'd1;
        end
    end

endmodule

// File: rtl/bpred_btb.sv
// bpred_btb: direct-mapped BTB with 2-bit direction counters, saturating
// mispredict counter and self-clearing init sweep. Define BPRED_GHR_EN for gshare indexing.
module bpred_btb
    import bpred_pkg::*;
#(
    parameter int ADDR_W  = 16,
    parameter int ENTRIES = 16,
    parameter int GHR_W   = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear_req,
    input  logic [ADDR_W-1:0] lookup_pc,
    output logic              pred_hit,
    output logic              pred_taken,
    output logic [ADDR_W-1:0] pred_target,
    output logic [GHR_W-1:0]  pred_ghr,
    input  logic              update_valid,
    input  logic [ADDR_W-1:0] update_pc,
    input  logic              update_taken,
    input  logic [ADDR_W-1:0] update_target,
    input  logic              update_mispredict,
    input  logic [GHR_W-1:0]  update_ghr,
    output logic              busy,
    output logic [15:0]       miss_count
);

    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = ADDR_W - IDX_W;

    state_t            r_state, w_state_nxt;
    logic [IDX_W-1:0]  r_sweep_idx, w_sweep_nxt;
    logic              w_sweep_clr;
    logic              r_rst_hold;

    logic              r_valid  [ENTRIES];
    logic [TAG_W-1:0]  r_tag    [ENTRIES];
    logic [ADDR_W-1:0] r_target [ENTRIES];
    cnt_t              r_cnt    [ENTRIES];
    logic [15:0]       r_miss_count;

    logic [IDX_W-1:0]  w_lk_idx, w_up_idx;
    logic [TAG_W-1:0]  w_lk_tag, w_up_tag;
    logic              w_run, w_up_acc, w_up_hit, w_lk_hit;
    cnt_t              w_cnt_nxt;

    assign w_lk_tag = lookup_pc[ADDR_W-1:IDX_W];
    assign w_up_tag = update_pc[ADDR_W-1:IDX_W];

`ifdef BPRED_GHR_EN
    logic [GHR_W-1:0] r_ghr;

    assign w_lk_idx = lookup_pc[IDX_W-1:0] ^ IDX_W'(r_ghr);
    assign w_up_idx = update_pc[IDX_W-1:0] ^ IDX_W'(update_ghr);
    assign pred_ghr = r_ghr;

    // Shift in the resolved direction; the cast drops the oldest bit.
    always_ff @(posedge clk) begin
        if (!reset || clear_req) r_ghr <= '0;
        else if (w_up_acc)       r_ghr <= GHR_W'({r_ghr, update_taken});
    end
`else
    logic w_unused_ghr;

    assign w_lk_idx     = lookup_pc[IDX_W-1:0];
    assign w_up_idx     = update_pc[IDX_W-1:0];
    assign pred_ghr     = '0;
    assign w_unused_ghr = ^update_ghr;
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state     <= ST_INIT;
            r_sweep_idx <= '0;
            r_rst_hold  <= 1'b1;
        end else begin
            r_state     <= w_state_nxt;
            r_sweep_idx <= w_sweep_nxt;
            r_rst_hold  <= 1'b0;
        end
    end

    // The first edge after reset release restarts the sweep like a clear,
    // so both entry paths give the same busy window.
    always_comb begin
        w_state_nxt = r_state;
        w_sweep_nxt = r_sweep_idx;
        w_sweep_clr = 1'b0;
        case (r_state)
            ST_INIT: begin
                if (clear_req || r_rst_hold) begin
                    w_sweep_nxt = '0;
                end else begin
                    w_sweep_clr = 1'b1;
                    if (r_sweep_idx == IDX_W'(ENTRIES - 1)) begin
                        w_state_nxt = ST_RUN;
                        w_sweep_nxt = '0;
                    end else begin
                        w_sweep_nxt = r_sweep_idx + IDX_W'(1);
                    end
                end
            end
            ST_RUN: begin
                if (clear_req) begin
                    w_state_nxt = ST_INIT;
                    w_sweep_nxt = '0;
                end
            end
            default: w_state_nxt = ST_INIT;
        endcase
    end

    assign w_run    = (r_state == ST_RUN);
    assign busy     = ~w_run;
    assign w_up_acc = w_run && update_valid && !clear_req;
    assign w_up_hit = r_valid[w_up_idx] && (r_tag[w_up_idx] == w_up_tag);

    satcnt2 u_satcnt2 (
        .i_cnt (r_cnt[w_up_idx]),
        .i_inc (update_taken),
        .o_cnt (w_cnt_nxt)
    );

    always_ff @(posedge clk) begin
        if (w_sweep_clr)
            r_valid[r_sweep_idx] <= 1'b0;
        else if (w_up_acc && update_taken && !w_up_hit)
            r_valid[w_up_idx] <= 1'b1;
    end

    // Taken updates (re)write tag and target; a miss allocates weakly taken.
    always_ff @(posedge clk) begin
        if (w_up_acc) begin
            if (update_taken) begin
                r_tag[w_up_idx]    <= w_up_tag;
                r_target[w_up_idx] <= update_target;
                r_cnt[w_up_idx]    <= w_up_hit ? w_cnt_nxt : CNT_INIT;
            end else if (w_up_hit) begin
                r_cnt[w_up_idx]    <= w_cnt_nxt;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset)
            r_miss_count <= '0;
        else if (w_up_acc && update_mispredict)
            r_miss_count <= miss_inc(r_miss_count);
    end

    assign miss_count  = r_miss_count;
    assign w_lk_hit    = w_run && r_valid[w_lk_idx] && (r_tag[w_lk_idx] == w_lk_tag);
    assign pred_hit    = w_lk_hit;
    assign pred_taken  = w_lk_hit && r_cnt[w_lk_idx][1];
    assign pred_target = pred_taken ? r_target[w_lk_idx] : lookup_pc + ADDR_W'(1);

endmodule
